// File: rtl/filt_pkg.sv
// Constants shared between the 4-bit FIR smoothing filter and its decimator.
package filt_pkg;
    localparam int unsigned FILT_IN_W  = 4;
    localparam int unsigned FILT_OUT_W = 12;
    localparam int unsigned DEC_LOG2_N = 2;

    typedef logic [FILT_OUT_W-1:0] sample_t;
endpackage

// File: rtl/filt_fifo2.sv
// Two-entry synchronous FIFO; head entry is a dedicated register driving the output.
module filt_fifo2 #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    logic [W-1:0] tail;
    logic [1:0]   count;
    logic         pop_ok;
    logic         push_ok;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push to a full FIFO is still taken.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10: begin
                    if (empty) head <= push_data;
                    else       tail <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/filt_decimator.sv
// Block-average decimator (N = 2^LOG2_N) feeding a 2-entry valid/ready FIFO.
// Optional FILT_DECIMATOR_DROP_CNT_EN adds a saturating 8-bit drop_cnt output.
module filt_decimator
    import filt_pkg::*;
#(
    parameter int unsigned IN_W   = FILT_OUT_W,
    parameter int unsigned LOG2_N = DEC_LOG2_N,
    parameter int unsigned ACC_W  = IN_W + LOG2_N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] y,
    input  logic            y_valid,
    output logic [IN_W-1:0] dec_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic            overflow
`ifdef FILT_DECIMATOR_DROP_CNT_EN
    ,
    output logic [7:0]      drop_cnt
`endif
);
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic [LOG2_N-1:0] cnt;
    logic              res_valid;
    logic [IN_W-1:0]   res_data;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;

    assign sum       = acc + ACC_W'(y);
    assign dec_valid = !empty;
    assign pop       = dec_valid && dec_ready;
    assign drop      = res_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (y_valid) begin
                if (cnt == CNT_LAST) begin
                    // Floor average: drop the LOG2_N low bits of the full sum.
                    res_data  <= sum[IN_W+LOG2_N-1:LOG2_N];
                    res_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + LOG2_N'(1);
                end
            end
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef FILT_DECIMATOR_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                           drop_cnt <= '0;
        else if (drop && drop_cnt != '1)   drop_cnt <= drop_cnt + 8'd1;
    end
`endif

    filt_fifo2 #(.W(IN_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (res_valid),
        .push_data (res_data),
        .pop       (pop),
        .head      (dec_data),
        .empty     (empty),
        .full      (full)
    );
endmodule
